// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg: shared types and helpers for the regfile writeback controller
package regfile_ctrl_pkg;
  localparam int NUM_REGS = 32;
  typedef logic [4:0] reg_addr_t;
  typedef logic [31:0] xlen_data_t;
  typedef enum logic {LD_PRIO, ALU_PRIO} wb_arb_state_e;
  function automatic logic src_hazard(logic en, reg_addr_t a, logic [NUM_REGS-1:0] pend, logic wen, reg_addr_t waddr);
    return en && a != '0 && (pend[a] || (wen && waddr == a));
  endfunction
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// regfile_wb_ctrl_if: ALU writeback, load issue/response, decode and regfile write signals
interface regfile_wb_ctrl_if;
  import regfile_ctrl_pkg::*;
  logic alu_wb_valid_i;
  reg_addr_t alu_wb_rd_i;
  xlen_data_t alu_wb_data_i;
  logic alu_wb_ready_o;
  logic ld_issue_i;
  reg_addr_t ld_issue_rd_i;
  logic ld_issue_ready_o;
  logic ld_rsp_valid_i;
  reg_addr_t ld_rsp_rd_i;
  xlen_data_t ld_rsp_data_i;
  logic ld_rsp_ready_o;
  reg_addr_t rs1_addr_i;
  reg_addr_t rs2_addr_i;
  logic rs1_use_i;
  logic rs2_use_i;
  logic hazard_o;
  logic rf_wr_en_o;
  reg_addr_t rf_rd_addr_o;
  xlen_data_t rf_wr_data_o;
  modport master (
    output alu_wb_valid_i, alu_wb_rd_i, alu_wb_data_i, ld_issue_i, ld_issue_rd_i,
           ld_rsp_valid_i, ld_rsp_rd_i, ld_rsp_data_i, rs1_addr_i, rs2_addr_i, rs1_use_i, rs2_use_i,
    input  alu_wb_ready_o, ld_issue_ready_o, ld_rsp_ready_o, hazard_o, rf_wr_en_o, rf_rd_addr_o, rf_wr_data_o
  );
  modport slave (
    input  alu_wb_valid_i, alu_wb_rd_i, alu_wb_data_i, ld_issue_i, ld_issue_rd_i,
           ld_rsp_valid_i, ld_rsp_rd_i, ld_rsp_data_i, rs1_addr_i, rs2_addr_i, rs1_use_i, rs2_use_i,
    output alu_wb_ready_o, ld_issue_ready_o, ld_rsp_ready_o, hazard_o, rf_wr_en_o, rf_rd_addr_o, rf_wr_data_o
  );
endinterface

// File: rtl/load_scoreboard.sv
// load_scoreboard: per-register pending-load bits and outstanding load count
module load_scoreboard
  import regfile_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic issue_i,
  input  reg_addr_t issue_rd_i,
  input  logic clr_i,
  input  reg_addr_t clr_rd_i,
  output logic issue_ready_o,
  output logic [NUM_REGS-1:0] pending_o
);
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic issue_acc, dec;
  // set wins over clear so a same-cycle reissue keeps the register pending; count saturates at zero for late responses
  always_comb begin
    issue_ready_o = cnt_q < CW'(MAX_OUTSTANDING);
    issue_acc = issue_i && issue_ready_o;
    dec = clr_i && cnt_q != '0;
    pend_d = (pend_q & ~(clr_i ? NUM_REGS'(1) << clr_rd_i : '0))
           | ((issue_acc && issue_rd_i != '0) ? NUM_REGS'(1) << issue_rd_i : '0);
    cnt_d = cnt_q + CW'(issue_acc) - CW'(dec);
    pending_o = pend_q;
  end
  // scoreboard state register
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pend_q <= '0;
      cnt_q <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: arbitrates the regfile write port between ALU writeback and load responses
module regfile_wb_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int MAX_WAIT = 3,
  localparam int WW = $clog2(MAX_WAIT + 1)
) (
  input logic clk,
  input logic reset,
  regfile_wb_ctrl_if.slave bus
);
  wb_arb_state_e state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [NUM_REGS-1:0] pending;
  logic alu_elig, alu_gnt, ld_gnt;
  logic wen_q, wen_d;
  reg_addr_t addr_q, addr_d;
  xlen_data_t data_q, data_d;
  load_scoreboard #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_sb (
    .clk(clk),
    .reset(reset),
    .issue_i(bus.ld_issue_i),
    .issue_rd_i(bus.ld_issue_rd_i),
    .clr_i(ld_gnt),
    .clr_rd_i(bus.ld_rsp_rd_i),
    .issue_ready_o(bus.ld_issue_ready_o),
    .pending_o(pending)
  );
  // grant, starvation counter, priority FSM next state, write stage next values and hazard
  always_comb begin
    alu_elig = bus.alu_wb_valid_i && !pending[bus.alu_wb_rd_i];
    alu_gnt = alu_elig && (!bus.ld_rsp_valid_i || state_q == ALU_PRIO);
    ld_gnt = bus.ld_rsp_valid_i && !alu_gnt;
    wait_d = alu_gnt ? '0 : (alu_elig && ld_gnt) ? wait_q + 1'b1 : wait_q;
    state_d = state_q == ALU_PRIO ? (alu_gnt ? LD_PRIO : ALU_PRIO)
                                  : (wait_d == WW'(MAX_WAIT) ? ALU_PRIO : LD_PRIO);
    wen_d = alu_gnt ? bus.alu_wb_rd_i != '0 : ld_gnt && bus.ld_rsp_rd_i != '0;
    addr_d = alu_gnt ? bus.alu_wb_rd_i : ld_gnt ? bus.ld_rsp_rd_i : addr_q;
    data_d = alu_gnt ? bus.alu_wb_data_i : ld_gnt ? bus.ld_rsp_data_i : data_q;
    bus.alu_wb_ready_o = alu_gnt;
    bus.ld_rsp_ready_o = ld_gnt;
    bus.hazard_o = src_hazard(bus.rs1_use_i, bus.rs1_addr_i, pending, wen_q, addr_q)
                || src_hazard(bus.rs2_use_i, bus.rs2_addr_i, pending, wen_q, addr_q)
                || (bus.alu_wb_valid_i && !alu_gnt);
    bus.rf_wr_en_o = wen_q;
    bus.rf_rd_addr_o = addr_q;
    bus.rf_wr_data_o = data_q;
  end
  // arbiter state and registered regfile write stage
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= LD_PRIO;
      wait_q <= '0;
      wen_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      wen_q <= wen_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed vectors, corner sequences and a random run against a reference model
module tb_regfile_wb_ctrl;
  import regfile_ctrl_pkg::*;
  localparam int MAX_OUT = 4;
  localparam int MAX_WAIT = 3;
  typedef struct {
    logic av; reg_addr_t ard; xlen_data_t adat;
    logic iss; reg_addr_t ird;
    logic rv; reg_addr_t rrd; xlen_data_t rdat;
    reg_addr_t rs1; logic u1; reg_addr_t rs2; logic u2;
  } in_t;
  typedef struct {
    in_t i;
    logic ardy, lrdy, irdy, haz, wen;
    reg_addr_t addr;
    xlen_data_t data;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  regfile_wb_ctrl_if bus();
  regfile_wb_ctrl #(.MAX_OUTSTANDING(MAX_OUT), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  task automatic chk(string tag, string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s.%s: got %0h expected %0h at %0t", tag, name, act, exp, $time);
    end
  endtask
  function automatic in_t idle();
    in_t v;
    v = '{default: '0};
    return v;
  endfunction
  function automatic vec_t mk(in_t i, logic ardy, logic lrdy, logic irdy, logic haz, logic wen, reg_addr_t addr, xlen_data_t data);
    vec_t e;
    e.i = i; e.ardy = ardy; e.lrdy = lrdy; e.irdy = irdy; e.haz = haz;
    e.wen = wen; e.addr = addr; e.data = data;
    return e;
  endfunction
  task automatic apply(in_t v);
    bus.alu_wb_valid_i = v.av; bus.alu_wb_rd_i = v.ard; bus.alu_wb_data_i = v.adat;
    bus.ld_issue_i = v.iss; bus.ld_issue_rd_i = v.ird;
    bus.ld_rsp_valid_i = v.rv; bus.ld_rsp_rd_i = v.rrd; bus.ld_rsp_data_i = v.rdat;
    bus.rs1_addr_i = v.rs1; bus.rs1_use_i = v.u1; bus.rs2_addr_i = v.rs2; bus.rs2_use_i = v.u2;
  endtask
  task automatic run_vec(vec_t e, string tag);
    apply(e.i);
    @(negedge clk);
    chk(tag, "alu_ready", bus.alu_wb_ready_o, e.ardy);
    chk(tag, "ld_rsp_ready", bus.ld_rsp_ready_o, e.lrdy);
    chk(tag, "ld_issue_ready", bus.ld_issue_ready_o, e.irdy);
    chk(tag, "hazard", bus.hazard_o, e.haz);
    @(posedge clk);
    #1;
    chk(tag, "rf_wr_en", bus.rf_wr_en_o, e.wen);
    chk(tag, "rf_rd_addr", bus.rf_rd_addr_o, e.addr);
    chk(tag, "rf_wr_data", bus.rf_wr_data_o, e.data);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    apply(idle());
    #1;
    chk("reset", "rf_wr_en", bus.rf_wr_en_o, 0);
    chk("reset", "rf_rd_addr", bus.rf_rd_addr_o, 0);
    chk("reset", "rf_wr_data", bus.rf_wr_data_o, 0);
    chk("reset", "hazard", bus.hazard_o, 0);
    chk("reset", "ld_issue_ready", bus.ld_issue_ready_o, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  bit pend[32];
  int cnt, wt;
  bit alu_turn;
  logic m_wen;
  reg_addr_t m_addr;
  xlen_data_t m_data;
  reg_addr_t q[$];
  vec_t tbl[$];
  initial begin
    in_t v;
    vec_t e;
    int k;
    bit aok, ag, lg, iok, aw;
    do_reset();
    v = idle(); v.av = 1; v.ard = 5; v.adat = 'h1234; tbl.push_back(mk(v, 1, 0, 1, 0, 1, 5, 'h1234));
    v = idle(); v.rs1 = 5; v.u1 = 1; tbl.push_back(mk(v, 0, 0, 1, 1, 0, 5, 'h1234));
    v = idle(); v.av = 1; v.ard = 0; v.adat = 'hFFFF; tbl.push_back(mk(v, 1, 0, 1, 0, 0, 0, 'hFFFF));
    v = idle(); v.iss = 1; v.ird = 0; v.u1 = 1; tbl.push_back(mk(v, 0, 0, 1, 0, 0, 0, 'hFFFF));
    v = idle(); v.iss = 1; v.ird = 3; tbl.push_back(mk(v, 0, 0, 1, 0, 0, 0, 'hFFFF));
    v = idle(); v.av = 1; v.ard = 3; v.adat = 'h55; v.rs1 = 3; v.u1 = 1; tbl.push_back(mk(v, 0, 0, 1, 1, 0, 0, 'hFFFF));
    v.rv = 1; v.rrd = 3; v.rdat = 'hAA; tbl.push_back(mk(v, 0, 1, 1, 1, 1, 3, 'hAA));
    v.rv = 0; tbl.push_back(mk(v, 1, 0, 1, 1, 1, 3, 'h55));
    v = idle(); v.rs1 = 3; v.u1 = 1; tbl.push_back(mk(v, 0, 0, 1, 1, 0, 3, 'h55));
    tbl.push_back(mk(v, 0, 0, 1, 0, 0, 3, 'h55));
    v = idle(); v.rv = 1; v.rrd = 0; v.rdat = 'h77; v.u2 = 1; tbl.push_back(mk(v, 0, 1, 1, 0, 0, 0, 'h77));
    for (int i = 0; i < 8; i++) begin
      aw = (i % 4) == 3;
      v = idle(); v.av = 1; v.ard = 7; v.adat = 'h700 + i; v.rv = 1; v.rrd = 9; v.rdat = 'h900 + i;
      tbl.push_back(mk(v, aw, !aw, 1, !aw, 1, aw ? 5'd7 : 5'd9, aw ? 'h700 + i : 'h900 + i));
    end
    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      v = idle(); v.iss = 1; v.ird = reg_addr_t'(r); run_vec(mk(v, 0, 0, 1, 0, 0, 0, 0), "lim_issue");
    end
    v = idle(); v.rv = 1; v.rrd = 2; v.rdat = 'h22; v.iss = 1; v.ird = 5; run_vec(mk(v, 0, 1, 0, 0, 1, 2, 'h22), "lim_full");
    v = idle(); v.rs1 = 5; v.u1 = 1; run_vec(mk(v, 0, 0, 1, 0, 0, 2, 'h22), "lim_freed");
    v = idle(); v.iss = 1; v.ird = 1; v.rv = 1; v.rrd = 1; v.rdat = 'h11; run_vec(mk(v, 0, 1, 1, 0, 1, 1, 'h11), "same_rd");
    v = idle(); v.rs1 = 1; v.u1 = 1; run_vec(mk(v, 0, 0, 1, 1, 0, 1, 'h11), "same_rd_wb");
    v.iss = 1; v.ird = 6; run_vec(mk(v, 0, 0, 1, 1, 0, 1, 'h11), "same_rd_sb");
    v = idle(); v.av = 1; v.ard = 8; v.adat = 'h88; run_vec(mk(v, 1, 0, 0, 0, 1, 8, 'h88), "full_alu");
    v = idle(); v.rs1 = 3; v.u1 = 1; apply(v);
    @(negedge clk);
    chk("pre_rst", "hazard", bus.hazard_o, 1);
    chk("pre_rst", "ld_issue_ready", bus.ld_issue_ready_o, 0);
    chk("pre_rst", "rf_wr_en", bus.rf_wr_en_o, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst", "rf_wr_en", bus.rf_wr_en_o, 0);
    chk("mid_rst", "hazard", bus.hazard_o, 0);
    chk("mid_rst", "ld_issue_ready", bus.ld_issue_ready_o, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    v = idle(); v.rv = 1; v.rrd = 3; v.rdat = 'hBB; run_vec(mk(v, 0, 1, 1, 0, 1, 3, 'hBB), "late_rsp");
    v = idle(); v.iss = 1; v.ird = 4; run_vec(mk(v, 0, 0, 1, 0, 0, 3, 'hBB), "no_underflow");
    v = idle(); v.rs1 = 4; v.u1 = 1; run_vec(mk(v, 0, 0, 1, 1, 0, 3, 'hBB), "post_rst_sb");
    do_reset();
    foreach (pend[i]) pend[i] = 0;
    cnt = 0; wt = 0; alu_turn = 0; m_wen = 0; m_addr = 0; m_data = 0; q.delete();
    for (int c = 0; c < 400; c++) begin
      v = idle();
      k = -1;
      v.av = $urandom_range(0, 9) < 6;
      v.ard = reg_addr_t'($urandom_range(0, 7));
      v.adat = $urandom;
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, q.size() - 1);
        v.rv = 1; v.rrd = q[k]; v.rdat = $urandom;
      end
      if ($urandom_range(0, 9) < 4) begin
        v.ird = reg_addr_t'($urandom_range(0, 7));
        v.iss = !pend[v.ird];
      end
      v.rs1 = reg_addr_t'($urandom_range(0, 7)); v.u1 = $urandom_range(0, 1) == 1;
      v.rs2 = reg_addr_t'($urandom_range(0, 7)); v.u2 = $urandom_range(0, 1) == 1;
      aok = v.av && !pend[v.ard];
      ag = aok && (!v.rv || alu_turn);
      lg = v.rv && !ag;
      iok = v.iss && cnt < MAX_OUT;
      assert (!(iok && v.ird != 0 && pend[v.ird]));
      assert (!(lg && cnt == 0));
      e.i = v; e.ardy = ag; e.lrdy = lg; e.irdy = cnt < MAX_OUT;
      e.haz = (v.u1 && v.rs1 != 0 && (pend[v.rs1] || (m_wen && m_addr == v.rs1)))
           || (v.u2 && v.rs2 != 0 && (pend[v.rs2] || (m_wen && m_addr == v.rs2)))
           || (v.av && !ag);
      if (ag) begin m_wen = v.ard != 0; m_addr = v.ard; m_data = v.adat; end
      else if (lg) begin m_wen = v.rrd != 0; m_addr = v.rrd; m_data = v.rdat; end
      else m_wen = 0;
      e.wen = m_wen; e.addr = m_addr; e.data = m_data;
      run_vec(e, "rand");
      if (lg) begin pend[v.rrd] = 0; q.delete(k); cnt--; end
      if (iok) begin if (v.ird != 0) pend[v.ird] = 1; cnt++; q.push_back(v.ird); end
      if (ag) begin wt = 0; alu_turn = 0; end
      else if (aok && lg) begin wt++; if (wt >= MAX_WAIT) alu_turn = 1; end
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Owns the single write port of the 32x32 register file. Arbitrates it between ALU writeback and out-of-order load responses.
- Keeps a pending-load scoreboard over x1..x31 and raises a decode hazard when a source or destination register is still pending.
- Sits between the execute/load units and the regfile. Enables the move from single-cycle loads to multi-cycle memory.

Parameters:
- MAX_OUTSTANDING, 4, max loads issued but not yet written back (1..31).
- MAX_WAIT, 3, consecutive cycles ALU may be blocked by loads before it gets priority (>=1).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- alu_wb_valid_i  in  1  ALU result ready for writeback
- alu_wb_rd_i  in  5  ALU destination register
- alu_wb_data_i  in  32  ALU result
- alu_wb_ready_o  out  1  ALU writeback accepted this cycle
- ld_issue_i  in  1  load issued this cycle (mark rd pending)
- ld_issue_rd_i  in  5  load destination register
- ld_issue_ready_o  out  1  load may issue (outstanding < MAX_OUTSTANDING)
- ld_rsp_valid_i  in  1  load data returned
- ld_rsp_rd_i  in  5  returned load destination
- ld_rsp_data_i  in  32  returned load data
- ld_rsp_ready_o  out  1  load response accepted this cycle
- rs1_addr_i, rs2_addr_i  in  5 each  decode source registers
- rs1_use_i, rs2_use_i  in  1 each  source actually read by instruction
- hazard_o  out  1  decode must stall
- rf_wr_en_o  out  1  regfile write enable (registered)
- rf_rd_addr_o  out  5  regfile write address (registered)
- rf_wr_data_o  out  32  regfile write data (registered)

Behaviour:
- Reset (async, immediate):
  - rf_wr_en_o=0, rf_rd_addr_o=0, rf_wr_data_o=0.
  - Scoreboard=0, outstanding count=0, wait counter=0, FSM=LD_PRIO.
  - Combinational outputs then evaluate from cleared state.
- Reset mid-operation drops all pending loads. A late ld_rsp after reset deassertion is accepted and written normally; no scoreboard bit exists to clear.
- FSM, two states:
  - LD_PRIO: load response wins a conflict.
  - ALU_PRIO: ALU wins a conflict.
  - LD_PRIO->ALU_PRIO when wait counter reaches MAX_WAIT. Wait counter increments each cycle alu_wb_valid_i=1 and is not accepted only because of a load grant.
  - ALU_PRIO->LD_PRIO after exactly one ALU accept. Wait counter clears on any ALU accept.
- ALU eligibility: alu_wb_valid_i=1 and scoreboard[alu_wb_rd_i]=0. Writing a pending rd stalls the ALU to preserve WAW order. rd=0 is always eligible.
- Load eligibility: ld_rsp_valid_i=1.
- Grant: at most one of alu_wb_ready_o / ld_rsp_ready_o per cycle. Non-conflicting requester is granted alone.
- Write stage, one-cycle latency:
  - On a grant, next edge loads rf_rd_addr_o/rf_wr_data_o from the winner.
  - rf_wr_en_o=1 only if granted rd!=0.
  - With no grant, rf_wr_en_o=0 and address/data hold.
- Scoreboard:
  - ld_issue_i && ld_issue_ready_o && rd!=0 sets bit rd and increments count.
  - Accepted ld_rsp clears bit rd and decrements count.
  - Issue and response to the same rd in one cycle leave the bit set and the count unchanged.
  - Issue to an already-pending rd is a protocol violation; the bench asserts it never happens.
  - A load to rd=0 still occupies a count slot.
- ld_issue_ready_o = (count < MAX_OUTSTANDING), combinational from registered count. A same-cycle response does not free a slot early.
- hazard_o asserts if any of:
  - (rs1_use_i and rs1!=0 and (scoreboard[rs1] or (rf_wr_en_o and rf_rd_addr_o==rs1)))
  - same term for rs2
  - alu_wb_valid_i and not alu_wb_ready_o
- Count width: clog2(MAX_OUTSTANDING+1). Count never wraps; the bench asserts no underflow.

Decomposition:
- Package regfile_ctrl_pkg:
  - typedef reg_addr_t (logic [4:0])
  - typedef xlen_data_t (logic [31:0])
  - NUM_REGS=32
  - enum wb_arb_state_e {LD_PRIO, ALU_PRIO}
- One sub-module, load_scoreboard: pending vector, outstanding count, set/clear and query ports. Arbiter FSM and write stage stay in the top.

Test Plan:
- ALU only: alu valid rd=5 data=0x1234 -> ready same cycle; next edge rf_wr_en_o=1, addr=5, data=0x1234; hazard_o=0.
- Conflict/starvation, MAX_WAIT=3: ALU rd=7 and ld_rsp rd=9 both valid every cycle -> loads granted 3 cycles, ALU granted cycle 4, then loads resume.
- Scoreboard hazard: issue load rd=3; next cycle rs1=3 use=1 -> hazard_o=1. Response rd=3 data=0xAA accepted -> hazard_o held one more cycle (write stage), then 0. ALU rd=3 is stalled until the response is accepted.
- Outstanding limit, MAX_OUTSTANDING=4: issue rd=1..4 -> ld_issue_ready_o=0. One response -> ready=1 the following cycle.
- rd=0: ALU write rd=0 data=0xFFFF -> accepted, rf_wr_en_o stays 0. Load issue to rd=0 -> no hazard on rs1=0.
- Reset mid-flight: 2 loads pending, assert reset asynchronously between edges -> rf_wr_en_o=0, hazard_o=0, ld_issue_ready_o=1 immediately.
